multiplier_top: RTL and testbench
=================================

// Module: multiplier_top
//
// PURPOSE
//  Registered unsigned N x N multiplier with independent operand-load enables.
//  Operand A and operand B are each captured into an internal register when
//  their enable is high. The 2N-bit product of the two stored operands is
//  registered onto P_out every cycle.
//  Used as a standalone arithmetic block; width is set at elaboration (8/16/32).
//
// PARAMETERS
//  N   default 8   operand width in bits; product is 2*N bits; legal N >= 2
//
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  Reset      in   1     asynchronous, active-low reset
//  Data_in_A  in   N     operand A data
//  Data_in_B  in   N     operand B data
//  EA         in   1     load enable for operand register A
//  EB         in   1     load enable for operand register B
//  P_out      out  2N    registered product RegA*RegB
//
// BEHAVIOUR
//  - Reset low (any time, asynchronous): RegA=0, RegB=0, P_out=0 immediately.
//    Held at 0 while Reset is low; EA/EB are ignored during reset.
//  - Rising edge with EA=1: RegA <= Data_in_A. With EA=0, RegA holds.
//    EB/RegB/Data_in_B behave identically and independently.
//  - EA and EB may be high together: both registers load on the same edge.
//  - Every rising edge (out of reset): P_out <= RegA * RegB.
//    RegA/RegB are the values before that edge.
//  - Latency: operands loaded at edge k appear on P_out after edge k+1.
//    P_out then stays constant until a register is reloaded.
//  - Arithmetic: unsigned, full 2N-bit result, no truncation or overflow.
//    Max case: (2^N-1)^2 = 2^2N - 2^(N+1) + 1.
//  - Reload of one operand only: the new product uses the new value and the
//    retained other operand, with the same 1-cycle latency.
//  - Reset released mid-stream: first product after release is 0*0 = 0
//    until operands are loaded.
//  - No handshake and no busy state: a new operand may be loaded every cycle.
//    Throughput is one product per clock.
//
// STRUCTURE
//  - No shared package needed; widths derive locally from N.
//    Local constant PW = 2*N.
//  - One sub-module: mult_array #(N): purely combinational unsigned N x N
//    array multiplier.
//    - Partial products AND-gated.
//    - Summed by generate-built rows of full/half adders.
//    - Output is 2N bits.
//  - Top level contains the two enable registers, mult_array, and the P_out
//    register. No `*` operator in RTL; the array is explicit.
//
// TESTING (N=8 unless noted)
//  1. Reset low mid-operation (P_out=0x1234) -> P_out=0 at once, before any
//     clk edge; stays 0 while Reset is low.
//  2. A=12, B=10, EA=EB=1 for one edge -> P_out=120 (0x0078) one edge later;
//     holds with EA=EB=0.
//  3. A=255, B=255 -> P_out=65025 (0xFE01); A=0, B=200 -> P_out=0.
//  4. Load A=7 only, then B=9 on a later edge -> P_out=0 (B still 0), then 63.
//     Then EA=1 with A=3 -> 27.
//  5. EA=EB=0 while data inputs toggle randomly for 20 cycles -> P_out unchanged.
//  6. N=16 override: A=0xFFFF, B=0xFFFF -> P_out=0xFFFE0001.
//     Random back-to-back loads checked against a reference model with
//     1-cycle latency.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Bit-level adder cells shared by the array multiplier.
package multiplier_pkg;

    // Returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/mult_array.sv
// Combinational unsigned N x N ripple-carry array multiplier with a 2N-bit product.
module mult_array
    import multiplier_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    localparam int unsigned PW = 2 * N;

    logic [N-1:0][N-1:0] pp;
    // Row i holds (row i-1 >> 1) + pp[i]; its LSB is final product bit i.
    logic [N-1:0][N:0]   acc;
    logic [N-1:1][N:1]   carry;

    for (genvar i = 0; i < N; i++) begin : g_pp_row
        for (genvar j = 0; j < N; j++) begin : g_pp_bit
            assign pp[i][j] = a[j] & b[i];
        end
    end

    assign acc[0] = {1'b0, pp[0]};

    for (genvar i = 1; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_bit
            if (j == 0) begin : g_ha
                assign {carry[i][1], acc[i][0]} = half_add(acc[i-1][1], pp[i][0]);
            end else begin : g_fa
                assign {carry[i][j+1], acc[i][j]} =
                    full_add(acc[i-1][j+1], pp[i][j], carry[i][j]);
            end
        end
        assign acc[i][N] = carry[i][N];
    end

    for (genvar i = 0; i < N - 1; i++) begin : g_low
        assign p[i] = acc[i][0];
    end

    assign p[PW-1:N-1] = acc[N-1];

endmodule

// File: rtl/multiplier_top.sv
// Registered unsigned N x N multiplier with independent operand-load enables.
module multiplier_top #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic [N-1:0]   Data_in_A,
    input  logic [N-1:0]   Data_in_B,
    input  logic           EA,
    input  logic           EB,
    output logic [2*N-1:0] P_out
);

    localparam int unsigned PW = 2 * N;

    logic [N-1:0]  reg_a_q;
    logic [N-1:0]  reg_b_q;
    logic [PW-1:0] prod;

    mult_array #(
        .N(N)
    ) u_mult_array (
        .a(reg_a_q),
        .b(reg_b_q),
        .p(prod)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            P_out   <= '0;
        end else begin
            if (EA) begin
                reg_a_q <= Data_in_A;
            end
            if (EB) begin
                reg_b_q <= Data_in_B;
            end
            // Product of the operands as they were before this edge.
            P_out <= prod;
        end
    end

endmodule

// File: tb/tb_multiplier_top.sv
// Directed and random checks of multiplier_top at N=8 and N=16 with a scoreboard queue.
module tb_multiplier_top;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  a8, b8;
    logic        ea8, eb8;
    logic [15:0] p8;
    logic [15:0] a16, b16;
    logic        ea16, eb16;
    logic [31:0] p16;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ma8, mb8;
    logic [15:0] ma16, mb16;
    logic [15:0] q8[$];
    logic [31:0] q16[$];

    always #5 clk = ~clk;

    multiplier_top #(
        .N(8)
    ) dut8 (
        .clk(clk),
        .Reset(Reset),
        .Data_in_A(a8),
        .Data_in_B(b8),
        .EA(ea8),
        .EB(eb8),
        .P_out(p8)
    );

    multiplier_top #(
        .N(16)
    ) dut16 (
        .clk(clk),
        .Reset(Reset),
        .Data_in_A(a16),
        .Data_in_B(b16),
        .EA(ea16),
        .EB(eb16),
        .P_out(p16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, push the product the DUT must show after this edge,
    // advance the operand model, then pop and compare.
    task automatic cycle(input string tag,
                         input logic e_a, input logic e_b, input logic [7:0] da, input logic [7:0] db,
                         input logic f_a, input logic f_b, input logic [15:0] wa, input logic [15:0] wb);
        logic [15:0] exp8;
        logic [31:0] exp16;
        ea8 = e_a; eb8 = e_b; a8 = da; b8 = db;
        ea16 = f_a; eb16 = f_b; a16 = wa; b16 = wb;
        q8.push_back(16'(ma8) * 16'(mb8));
        q16.push_back(32'(ma16) * 32'(mb16));
        if (e_a) ma8 = da;
        if (e_b) mb8 = db;
        if (f_a) ma16 = wa;
        if (f_b) mb16 = wb;
        @(posedge clk);
        #1;
        exp8 = q8.pop_front();
        exp16 = q16.pop_front();
        check({tag, "_p8"}, 32'(p8), 32'(exp8));
        check({tag, "_p16"}, p16, exp16);
    endtask

    initial begin
        Reset = 1'b0;
        {ea8, eb8, ea16, eb16} = '0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        ma8 = '0; mb8 = '0; ma16 = '0; mb16 = '0;
        #12;
        check("reset_p8", 32'(p8), 32'h0);
        check("reset_p16", p16, 32'h0);
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        #1;

        // Build P_out = 0x1234 (20*233), then assert reset mid-cycle.
        cycle("pre", 1, 1, 8'd20, 8'd233, 1, 1, 16'h1234, 16'h0002);
        cycle("hold1234", 0, 0, 8'd0, 8'd0, 0, 0, 16'h0, 16'h0);
        check("is1234", 32'(p8), 32'h1234);
        #3;
        Reset = 1'b0;
        #1;
        check("async_p8", 32'(p8), 32'h0);
        check("async_p16", p16, 32'h0);
        ea8 = 1; eb8 = 1; a8 = 8'd99; b8 = 8'd77;
        ea16 = 1; eb16 = 1; a16 = 16'hABCD; b16 = 16'h1111;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("inrst_p8", 32'(p8), 32'h0);
            check("inrst_p16", p16, 32'h0);
        end
        ma8 = '0; mb8 = '0; ma16 = '0; mb16 = '0;
        #3;
        Reset = 1'b1;
        cycle("postrst", 0, 0, 8'd5, 8'd5, 0, 0, 16'd5, 16'd5);

        // 12*10 = 120, then hold.
        cycle("ld12x10", 1, 1, 8'd12, 8'd10, 1, 1, 16'd12, 16'd10);
        cycle("p120", 0, 0, 8'd1, 8'd1, 0, 0, 16'd1, 16'd1);
        check("is0078", 32'(p8), 32'h0078);
        cycle("hold120", 0, 0, 8'd3, 8'd4, 0, 0, 16'd3, 16'd4);

        // Max case, then zero operand.
        cycle("ldmax", 1, 1, 8'hFF, 8'hFF, 1, 1, 16'hFFFF, 16'hFFFF);
        cycle("pmax", 1, 1, 8'd0, 8'd200, 0, 0, 16'd0, 16'd0);
        check("isFE01", 32'(p8), 32'hFE01);
        check("isFFFE0001", p16, 32'hFFFE0001);
        cycle("pzero", 0, 0, 8'd0, 8'd0, 0, 0, 16'd0, 16'd0);
        check("iszero", 32'(p8), 32'h0);

        // Independent loads: A=7 first, B=9 later, then A=3.
        cycle("rst2", 1, 1, 8'd0, 8'd0, 1, 1, 16'd0, 16'd0);
        cycle("ldA7", 1, 0, 8'd7, 8'd50, 1, 0, 16'd7, 16'd50);
        cycle("waitB", 0, 0, 8'd1, 8'd1, 0, 0, 16'd1, 16'd1);
        check("is0", 32'(p8), 32'h0);
        cycle("ldB9", 0, 1, 8'd60, 8'd9, 0, 1, 16'd60, 16'd9);
        cycle("p63", 1, 0, 8'd3, 8'd0, 1, 0, 16'd3, 16'd0);
        check("is63", 32'(p8), 32'd63);
        cycle("p27", 0, 0, 8'd0, 8'd0, 0, 0, 16'd0, 16'd0);
        check("is27", 32'(p8), 32'd27);

        // Enables low while data toggles: output must not move.
        for (int i = 0; i < 20; i++) begin
            cycle("noload", 0, 0, 8'($urandom), 8'($urandom), 0, 0,
                  16'($urandom), 16'($urandom));
        end
        check("still27", 32'(p8), 32'd27);

        // Random back-to-back loads.
        for (int i = 0; i < 40; i++) begin
            cycle("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        end
        cycle("flush", 0, 0, 8'd0, 8'd0, 0, 0, 16'd0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
